// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: sequential instruction fetch into a small FIFO with stall and flush; define FETCH_HALT_EN to stop fetching after an 8'hFF instruction
module instr_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W = 8,
  parameter int INSTR_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   mem_req,
  output logic [PC_W-1:0]        mem_addr,
  input  logic                   mem_valid,
  input  logic [INSTR_W-1:0]     mem_instr,
  input  logic [INSTR_W-1:0]     mem_data,
  input  logic                   stall,
  input  logic                   flush,
  input  logic [PC_W-1:0]        flush_pc,
  output logic                   out_valid,
  output logic [INSTR_W-1:0]     instr_out,
  output logic [INSTR_W-1:0]     data_out,
  output logic [PC_W-1:0]        pc_out,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [PC_W-1:0] pc;
  logic inflight, halted, push, pop, issue, halt_hit;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [INSTR_W-1:0] data_mem [DEPTH];
  logic [PC_W-1:0] pc_mem [DEPTH];
  assign push = mem_valid && inflight && !flush;
  assign pop = out_valid && !stall && !flush;
  assign issue = !flush && !inflight && count < FULL && !halted;
`ifdef FETCH_HALT_EN
  assign halt_hit = push && mem_instr == {INSTR_W{1'b1}};
`else
  assign halt_hit = 1'b0;
`endif
  assign out_valid = count != '0;
  assign instr_out = out_valid ? instr_mem[rd_ptr] : '0;
  assign data_out = out_valid ? data_mem[rd_ptr] : '0;
  assign pc_out = out_valid ? pc_mem[rd_ptr] : '0;
  // Fetch control: one outstanding request at a time, flush overrides everything
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pc <= '0;
      inflight <= 1'b0;
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      mem_req <= 1'b0;
      mem_addr <= '0;
      halted <= 1'b0;
    end else if (flush) begin
      pc <= flush_pc;
      inflight <= 1'b0;
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      mem_req <= 1'b0;
      halted <= 1'b0;
    end else begin
      mem_req <= issue;
      if (issue) begin
        mem_addr <= pc;
        pc <= pc + 1'b1;
      end
      inflight <= issue | (inflight & ~push);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      halted <= halted | halt_hit;
    end
  // FIFO storage: a slot is always free when a response lands
  always_ff @(posedge clk)
    if (push) begin
      instr_mem[wr_ptr] <= mem_instr;
      data_mem[wr_ptr] <= mem_data;
      pc_mem[wr_ptr] <= mem_addr;
    end
endmodule
